// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, mid-bit sampling, optional parity, and a
// valid/ack output register with overrun reporting for the register block.
module uart_rx #(
    parameter int DIV = 27
) (
    input  logic       clk_i,
    input  logic       resetn_i,
    input  logic       rx_i,
    input  logic [1:0] verify,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ack_i,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       overrun_o
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t     state, state_nxt;
    logic       sync1, sync2, prev;
    logic       fall;
    logic [DW-1:0] divcnt;
    logic       tick;
    logic [3:0] tcnt, tcnt_nxt;
    logic [2:0] bcnt, bcnt_nxt;
    logic [7:0] shreg, shreg_nxt;
    logic [1:0] verify_q, verify_nxt;
    logic       perr, perr_nxt;
    logic       done;

    // Synchroniser resets to idle-high so a line held low out of reset reads as an edge.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= rx_i;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign fall = prev & ~sync2;

    // Divider is parked at zero in IDLE so tick phase is aligned to the start edge.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            divcnt <= '0;
        end else if (state == IDLE || divcnt == DIV_LAST) begin
            divcnt <= '0;
        end else begin
            divcnt <= divcnt + 1'b1;
        end
    end

    assign tick = (state != IDLE) && (divcnt == DIV_LAST);

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state    <= IDLE;
            tcnt     <= '0;
            bcnt     <= '0;
            shreg    <= '0;
            verify_q <= '0;
            perr     <= 1'b0;
        end else begin
            state    <= state_nxt;
            tcnt     <= tcnt_nxt;
            bcnt     <= bcnt_nxt;
            shreg    <= shreg_nxt;
            verify_q <= verify_nxt;
            perr     <= perr_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        tcnt_nxt   = tcnt;
        bcnt_nxt   = bcnt;
        shreg_nxt  = shreg;
        verify_nxt = verify_q;
        perr_nxt   = perr;
        done       = 1'b0;

        if (tick) begin
            tcnt_nxt = tcnt + 4'd1;
        end

        case (state)
            IDLE: begin
                tcnt_nxt = '0;
                bcnt_nxt = '0;
                if (fall) begin
                    state_nxt  = START;
                    verify_nxt = verify;
                    perr_nxt   = 1'b0;
                end
            end
            START: begin
                // A start bit that has gone high again by mid-bit was a glitch.
                if (tick && tcnt == 4'd7) begin
                    tcnt_nxt  = '0;
                    state_nxt = sync2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick && tcnt == 4'd15) begin
                    shreg_nxt = {sync2, shreg[7:1]};
                    bcnt_nxt  = bcnt + 3'd1;
                    if (bcnt == 3'd7) begin
                        state_nxt = verify_q[1] ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (tick && tcnt == 4'd15) begin
                    perr_nxt  = sync2 ^ (^shreg) ^ ~verify_q[0];
                    state_nxt = STOP;
                end
            end
            STOP: begin
                // Leaving at mid-stop lets a back-to-back start edge be seen.
                if (tick && tcnt == 4'd15) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // A completed frame only replaces held data if the consumer has taken it.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            data_o       <= '0;
            valid_o      <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            if (done) begin
                if (!valid_o || ack_i) begin
                    data_o       <= shreg;
                    parity_err_o <= perr;
                    frame_err_o  <= ~sync2;
                    valid_o      <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (valid_o && ack_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames against a frame-level model.
module tb_uart_rx;

    localparam int DIV = 4;
    localparam int BIT = 16 * DIV;

    logic       clk_i = 1'b0;
    logic       resetn_i;
    logic       rx_i;
    logic [1:0] verify;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ack_i;
    logic       parity_err_o;
    logic       frame_err_o;
    logic       overrun_o;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int frame_start = 0;
    int rise_count = 0;
    int rise_cyc = 0;
    int fall_count = 0;
    int ovr_cycles = 0;
    int ovr_pulses = 0;
    logic valid_q = 1'b0;
    logic ovr_q = 1'b0;

    logic       m_valid;
    logic [7:0] m_data;
    logic       m_perr;
    logic       m_ferr;
    int         m_ovr;

    uart_rx #(.DIV(DIV)) dut (
        .clk_i       (clk_i),
        .resetn_i    (resetn_i),
        .rx_i        (rx_i),
        .verify      (verify),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ack_i       (ack_i),
        .parity_err_o(parity_err_o),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Output event monitor: valid edges and overrun pulse shape.
    always @(negedge clk_i) begin
        if (valid_o && !valid_q) begin
            rise_count = rise_count + 1;
            rise_cyc = cyc;
        end
        if (!valid_o && valid_q) fall_count = fall_count + 1;
        valid_q = valid_o;
        if (overrun_o) ovr_cycles = ovr_cycles + 1;
        if (overrun_o && !ovr_q) ovr_pulses = ovr_pulses + 1;
        ovr_q = overrun_o;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkHeld(input string tag);
        checkOutput({tag, "_valid"}, 32'(valid_o), 32'(m_valid));
        checkOutput({tag, "_data"}, 32'(data_o), 32'(m_data));
        checkOutput({tag, "_perr"}, 32'(parity_err_o), 32'(m_perr));
        checkOutput({tag, "_ferr"}, 32'(frame_err_o), 32'(m_ferr));
        checkOutput({tag, "_ovr"}, ovr_pulses, m_ovr);
    endtask

    function automatic void modelFrame(input logic [7:0] d, input logic [1:0] v,
                                       input logic pbit, input logic stopb, input logic ack_at);
        if (!m_valid || ack_at) begin
            m_valid = 1'b1;
            m_data  = d;
            m_perr  = v[1] && (pbit != ((^d) ^ ~v[0]));
            m_ferr  = !stopb;
        end else begin
            m_ovr = m_ovr + 1;
        end
    endfunction

    // Drives one frame starting at the current negedge; rx_i is left at the stop level.
    task automatic applyStimulus(input logic [7:0] d, input logic [1:0] v, input logic pbit,
                                 input logic stopb, input logic scramble);
        verify = v;
        frame_start = cyc;
        rx_i = 1'b0;
        repeat (BIT) @(negedge clk_i);
        if (scramble) verify = 2'($urandom);
        for (int i = 0; i < 8; i++) begin
            rx_i = d[i];
            repeat (BIT) @(negedge clk_i);
        end
        if (v[1]) begin
            rx_i = pbit;
            repeat (BIT) @(negedge clk_i);
        end
        rx_i = stopb;
        repeat (BIT) @(negedge clk_i);
    endtask

    task automatic sendAndCheck(input string tag, input logic [7:0] d, input logic [1:0] v,
                                input logic pbit, input logic stopb, input logic scramble);
        int rc;
        logic was_valid;
        rc = rise_count;
        was_valid = m_valid;
        applyStimulus(d, v, pbit, stopb, scramble);
        modelFrame(d, v, pbit, stopb, 1'b0);
        if (!was_valid) begin
            checkOutput({tag, "_rise"}, rise_count - rc, 1);
            checkOutput({tag, "_latency"}, rise_cyc - frame_start,
                        2 + (v[1] ? 168 : 152) * DIV + 1);
        end
        checkHeld(tag);
    endtask

    task automatic idleLine(input int n);
        rx_i = 1'b1;
        repeat (n) @(negedge clk_i);
    endtask

    task automatic doAck(input string tag);
        ack_i = 1'b1;
        @(negedge clk_i);
        ack_i = 1'b0;
        m_valid = 1'b0;
        checkOutput({tag, "_valid"}, 32'(valid_o), 32'(m_valid));
        checkOutput({tag, "_data"}, 32'(data_o), 32'(m_data));
    endtask

    initial begin
        int rc;
        int fc;
        int c0;
        logic [7:0] rd;
        logic [1:0] rv;
        logic rp;
        logic rs;

        resetn_i = 1'b0;
        rx_i = 1'b1;
        ack_i = 1'b0;
        verify = 2'b00;
        m_valid = 1'b0;
        m_data = 8'h00;
        m_perr = 1'b0;
        m_ferr = 1'b0;
        m_ovr = 0;
        repeat (3) @(negedge clk_i);
        checkHeld("reset");
        checkOutput("reset_ovr_pin", 32'(overrun_o), 0);
        resetn_i = 1'b1;
        idleLine(20);

        sendAndCheck("a5", 8'hA5, 2'b00, 1'b0, 1'b1, 1'b0);
        idleLine(16);
        doAck("a5_ack");

        sendAndCheck("par_even_ok", 8'h03, 2'b11, 1'b0, 1'b1, 1'b0);
        idleLine(16);
        doAck("par_even_ok_ack");
        sendAndCheck("par_even_bad", 8'h03, 2'b11, 1'b1, 1'b1, 1'b0);
        idleLine(16);
        doAck("par_even_bad_ack");
        sendAndCheck("par_odd_ok", 8'h03, 2'b10, 1'b1, 1'b1, 1'b0);
        idleLine(16);
        doAck("par_odd_ok_ack");

        rc = rise_count;
        rx_i = 1'b0;
        repeat (12) @(negedge clk_i);
        idleLine(200);
        checkOutput("glitch_rise", rise_count - rc, 0);
        checkOutput("glitch_valid", 32'(valid_o), 0);
        sendAndCheck("after_glitch", 8'h5A, 2'b00, 1'b0, 1'b1, 1'b0);
        idleLine(16);
        doAck("after_glitch_ack");

        sendAndCheck("break", 8'h7E, 2'b00, 1'b0, 1'b0, 1'b0);
        doAck("break_ack");
        rc = rise_count;
        repeat (3 * BIT) @(negedge clk_i);
        checkOutput("break_hold_rise", rise_count - rc, 0);
        checkOutput("break_hold_valid", 32'(valid_o), 0);
        idleLine(BIT);
        sendAndCheck("after_break", 8'h3C, 2'b00, 1'b0, 1'b1, 1'b0);
        idleLine(16);
        doAck("after_break_ack");

        sendAndCheck("ovr_first", 8'h11, 2'b00, 1'b0, 1'b1, 1'b0);
        sendAndCheck("ovr_second", 8'h22, 2'b00, 1'b0, 1'b1, 1'b0);
        idleLine(16);
        checkOutput("ovr_width", ovr_cycles, ovr_pulses);
        doAck("ovr_ack");

        sendAndCheck("ackdone_first", 8'h11, 2'b00, 1'b0, 1'b1, 1'b0);
        fc = fall_count;
        c0 = cyc;
        fork
            applyStimulus(8'h22, 2'b00, 1'b0, 1'b1, 1'b0);
            begin
                while (cyc < c0 + 2 + 152 * DIV) @(negedge clk_i);
                ack_i = 1'b1;
                @(negedge clk_i);
                ack_i = 1'b0;
            end
        join
        modelFrame(8'h22, 2'b00, 1'b0, 1'b1, 1'b1);
        idleLine(16);
        checkHeld("ackdone_second");
        checkOutput("ackdone_no_drop", fall_count - fc, 0);

        rx_i = 1'b0;
        repeat (BIT) @(negedge clk_i);
        rx_i = 1'b1;
        repeat (4 * BIT + BIT / 2) @(negedge clk_i);
        resetn_i = 1'b0;
        #1;
        m_valid = 1'b0;
        m_data = 8'h00;
        m_perr = 1'b0;
        m_ferr = 1'b0;
        checkOutput("midreset_valid", 32'(valid_o), 0);
        checkOutput("midreset_data", 32'(data_o), 0);
        checkOutput("midreset_perr", 32'(parity_err_o), 0);
        checkOutput("midreset_ferr", 32'(frame_err_o), 0);
        checkOutput("midreset_ovr", 32'(overrun_o), 0);
        repeat (5) @(negedge clk_i);
        resetn_i = 1'b1;
        rc = rise_count;
        idleLine(7 * BIT);
        checkOutput("midreset_no_frame", rise_count - rc, 0);
        sendAndCheck("loop_c3", 8'hC3, 2'b00, 1'b0, 1'b1, 1'b0);
        idleLine(16);
        doAck("loop_c3_ack");

        for (int n = 0; n < 8; n++) begin
            rd = 8'($urandom);
            rv = 2'($urandom);
            rp = 1'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            sendAndCheck("rnd", rd, rv, rp, rs, 1'b1);
            idleLine(BIT);
            doAck("rnd_ack");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
